cdr_acq_ctl: RTL
================

# cdr_acq_ctl

Acquisition and lock sequencer for the baud-rate MM CDR. After `start`, it calibrates the auxiliary PD offset loop, then forces the phase interpolator through every code while measuring ADC sample magnitude. It parks the PI on the best code and hands control to the digital loop filter. While tracking, it watches for loss of lock and re-acquires. It runs on the parallel data clock and drives the CDR's `sel_ext_pi`, `pi_ctl_ext` and `sel_ext_pd_offset` controls.

## Interface
- Nadc, 8, ADC sample width (signed)
- Nti, 1, number of time-interleaved slices in `din`
- Npi, 8, PI control width; sweep covers codes 0..2^Npi-1
- Ncal, 10, log2 of aux-PD calibration dwell in cycles
- Nsettle, 4, log2 of PI settling cycles after every code change
- Nwin, 6, log2 of measurement window length in cycles
- Nm, Nadc+$clog2(Nti)+Nwin (localparam), metric accumulator width

- clk  in  1  parallel data clock (same clock as the CDR datapath)
- rstn  in  1  asynchronous, active-low reset
- start  in  1  level; high runs acquisition/tracking, low returns to IDLE
- din  in  signed [Nadc-1:0] x [Nti-1:0]  ADC outputs, one new vector per cycle
- lol_thresh  in  [Nm-1:0]  loss-of-lock threshold on window metric
- sel_ext_pi  out  1  high = PI driven from `pi_ctl_ext`
- pi_ctl_ext  out  [Npi-1:0]  forced PI code
- sel_ext_pd_offset  out  1  high = aux PD disabled, external offset used
- locked  out  1  high while in TRACK
- busy  out  1  high in CAL/SWEEP/HANDOFF
- best_code  out  [Npi-1:0]  code chosen by the last completed sweep

## Operation
- Metric: M = sum over window cycles and slices of |din[i]|.
  - |x| is computed in Nadc bits unsigned, so |-2^(Nadc-1)| = 2^(Nadc-1).
  - Accumulator is Nm bits and cannot overflow.
- States:
  - IDLE: `sel_ext_pi`=1, `sel_ext_pd_offset`=1, `pi_ctl_ext`=0. On `start`=1 → CAL.
  - CAL: `sel_ext_pd_offset`=0, `pi_ctl_ext`=0. Dwell 2^Ncal cycles, then → SETTLE with code 0, `best_metric`=0, `best_code_tmp`=0.
  - SETTLE: hold `pi_ctl_ext`=code for 2^Nsettle cycles, samples ignored, then → MEAS.
  - MEAS: accumulate M for 2^Nwin cycles.
    - At window end: if M > `best_metric` (strict), update `best_metric` and `best_code_tmp`. Ties therefore keep the lowest code.
    - If code < 2^Npi-1: code+1, → SETTLE. Otherwise → HANDOFF.
  - HANDOFF:
    - First cycle: `best_code` ← `best_code_tmp` and `pi_ctl_ext` ← `best_code_tmp`.
    - Hold 2^Nsettle cycles, then → TRACK.
  - TRACK: `sel_ext_pi`=0, `locked`=1.
    - Continuously measure back-to-back 2^Nwin windows.
    - A window with M < `lol_thresh` increments `lol_cnt`; a window with M ≥ `lol_thresh` clears it.
    - `lol_cnt`=2 → SETTLE with code 0 and best values cleared. CAL is skipped and the aux PD stays enabled.
- `start`=0 in any state → IDLE on the next edge; all counters cleared. `best_code` is retained.
- `sel_ext_pd_offset`=0 in every state except IDLE.

## Timing
- All outputs are registered. Reset values: `sel_ext_pi`=1, `pi_ctl_ext`=0, `sel_ext_pd_offset`=1, `locked`=0, `busy`=0, `best_code`=0.
- `start` rising at edge t → CAL entered at t+1; `busy`=1 and `sel_ext_pd_offset`=0 from t+1.
- Full-sweep duration is 2^Npi·(2^Nsettle+2^Nwin) cycles. With defaults this is 20480.
- MEAS accumulates the `din` registered on each of its 2^Nwin cycles. The decision is made on the last MEAS cycle; `pi_ctl_ext` changes on the following edge.
- `locked` rises on the same edge that `sel_ext_pi` falls. Loss-of-lock exit drops `locked`, raises `sel_ext_pi` and sets `pi_ctl_ext`=0 all on one edge.
- Reset mid-operation: immediate return to reset values; no partial `best_code` update.

## Test plan
Test parameters: Npi=3, Nwin=2, Nsettle=1, Ncal=3, Nti=1, Nadc=8.
- Reset/idle: `rstn` low then high, `start`=0 for 20 cycles → outputs stay at reset values; `busy`=0.
- Nominal sweep: `din`=10·(code==5 ? 4 : 1), `start`=1 → after 8 CAL cycles, codes 0..7 each held 6 cycles, then `best_code`=5, `pi_ctl_ext`=5. `locked`=1 and `sel_ext_pi`=0 at cycle 1+8+48+2.
- Tie + negative full scale: `din`=-128 at every code → M=512 each window; `best_code`=0 (lowest on ties); no overflow.
- Loss of lock: in TRACK with `lol_thresh`=100, drive `din`=10 (M=40) for two windows → `locked` falls after the 8th low cycle; sweep restarts at code 0 with no CAL. A single low window followed by a good one keeps lock.
- Abort: drop `start` during MEAS of code 3 → IDLE next edge; `sel_ext_pi`=1, `pi_ctl_ext`=0, `sel_ext_pd_offset`=1; `best_code` unchanged from the prior sweep.
- Async reset mid-sweep: assert `rstn` between edges during SETTLE → outputs return to reset values immediately, without waiting for `clk`.

Source files
------------

// File: rtl/cdr_acq_ctl.sv
// Acquisition and lock sequencer for the baud-rate MM CDR: aux-PD calibration,
// exhaustive PI sweep on ADC magnitude, hand-off to the loop filter and loss-of-lock re-acquisition.
module cdr_acq_ctl #(
  parameter int Nadc    = 8,
  parameter int Nti     = 1,
  parameter int Npi     = 8,
  parameter int Ncal    = 10,
  parameter int Nsettle = 4,
  parameter int Nwin    = 6,
  localparam int Nm     = Nadc + $clog2(Nti) + Nwin
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic signed [Nti-1:0][Nadc-1:0] din,
  input  logic [Nm-1:0]                   lol_thresh,
  output logic                            sel_ext_pi,
  output logic [Npi-1:0]                  pi_ctl_ext,
  output logic                            sel_ext_pd_offset,
  output logic                            locked,
  output logic                            busy,
  output logic [Npi-1:0]                  best_code
);

  localparam int CNT_W = (Ncal > Nsettle) ? ((Ncal > Nwin) ? Ncal : Nwin)
                                          : ((Nsettle > Nwin) ? Nsettle : Nwin);
  localparam logic [CNT_W-1:0] CAL_LAST    = CNT_W'((1 << Ncal) - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((1 << Nsettle) - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'((1 << Nwin) - 1);

  typedef enum logic [2:0] {
    IDLE, CAL, SETTLE, MEAS, HANDOFF, TRACK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [Npi-1:0]   code;
  logic [Nm-1:0]    acc;
  logic [Nm-1:0]    best_metric;
  logic [Npi-1:0]   best_code_tmp;
  logic [1:0]       lol_cnt;

  logic [Nm-1:0]    mag_sum;
  logic [Nm-1:0]    acc_next;
  logic             better;
  logic [Npi-1:0]   pick_code;
  logic [Nm-1:0]    pick_metric;

  // Magnitude in Nadc unsigned bits, so the most negative code maps to 2^(Nadc-1)
  function automatic logic [Nadc-1:0] abs_mag(input logic signed [Nadc-1:0] x);
    return x[Nadc-1] ? (~x + 1'b1) : x;
  endfunction

  // Stage 0: per-cycle slice magnitude sum and running window metric
  always_comb begin
    mag_sum = '0;
    for (int i = 0; i < Nti; i++) begin
      mag_sum = mag_sum + Nm'(abs_mag(din[i]));
    end
    acc_next    = acc + mag_sum;
    better      = (acc_next > best_metric);
    pick_code   = better ? code : best_code_tmp;
    pick_metric = better ? acc_next : best_metric;
  end

  // Stage 1: sequencer state and registered CDR controls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      cnt               <= '0;
      code              <= '0;
      acc               <= '0;
      best_metric       <= '0;
      best_code_tmp     <= '0;
      lol_cnt           <= '0;
      sel_ext_pi        <= 1'b1;
      pi_ctl_ext        <= '0;
      sel_ext_pd_offset <= 1'b1;
      locked            <= 1'b0;
      busy              <= 1'b0;
      best_code         <= '0;
    end else if (!start) begin
      state             <= IDLE;
      cnt               <= '0;
      code              <= '0;
      acc               <= '0;
      best_metric       <= '0;
      best_code_tmp     <= '0;
      lol_cnt           <= '0;
      sel_ext_pi        <= 1'b1;
      pi_ctl_ext        <= '0;
      sel_ext_pd_offset <= 1'b1;
      locked            <= 1'b0;
      busy              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state             <= CAL;
          cnt               <= '0;
          sel_ext_pd_offset <= 1'b0;
          busy              <= 1'b1;
        end
        CAL: begin
          if (cnt == CAL_LAST) begin
            state         <= SETTLE;
            cnt           <= '0;
            code          <= '0;
            pi_ctl_ext    <= '0;
            best_metric   <= '0;
            best_code_tmp <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= MEAS;
            cnt   <= '0;
            acc   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEAS: begin
          if (cnt == WIN_LAST) begin
            cnt           <= '0;
            acc           <= '0;
            best_metric   <= pick_metric;
            best_code_tmp <= pick_code;
            if (code != '1) begin
              state      <= SETTLE;
              code       <= code + 1'b1;
              pi_ctl_ext <= code + 1'b1;
            end else begin
              // Last window is folded in here so HANDOFF starts on the final winner
              state      <= HANDOFF;
              best_code  <= pick_code;
              pi_ctl_ext <= pick_code;
            end
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
        HANDOFF: begin
          if (cnt == SETTLE_LAST) begin
            state      <= TRACK;
            cnt        <= '0;
            acc        <= '0;
            lol_cnt    <= '0;
            sel_ext_pi <= 1'b0;
            locked     <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRACK: begin
          if (cnt == WIN_LAST) begin
            cnt <= '0;
            acc <= '0;
            if (acc_next < lol_thresh) begin
              if (lol_cnt == 2'd1) begin
                // Re-acquire without recalibrating; aux PD stays enabled
                state         <= SETTLE;
                code          <= '0;
                pi_ctl_ext    <= '0;
                best_metric   <= '0;
                best_code_tmp <= '0;
                lol_cnt       <= '0;
                sel_ext_pi    <= 1'b1;
                locked        <= 1'b0;
                busy          <= 1'b1;
              end else begin
                lol_cnt <= lol_cnt + 1'b1;
              end
            end else begin
              lol_cnt <= '0;
            end
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
